// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, types and helper functions for the iterative
// SHA-256/SHA-224 compression engine.
//   - K: the 64 round constants, K[0] first
//   - IV256 / IV224: initial hash values, H0 first
//   - ch, maj, bsig0, bsig1, ssig0, ssig1: the SHA-2 logical functions
//   - WorkVars: the eight working variables a..h (a in the top bits)
//   - core_state_e: engine FSM states
package sha256_pkg;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:7][31:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } WorkVars;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } core_state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// sha256_round_comb: one purely combinational SHA-256 round.
//   vars_in   in   WorkVars   working variables before the round
//   k_in      in   32         round constant K_t
//   w_in      in   32         schedule word W_t
//   vars_out  out  WorkVars   working variables after the round
module sha256_round_comb
  import sha256_pkg::*;
(
  input  WorkVars     vars_in,
  input  logic [31:0] k_in,
  input  logic [31:0] w_in,
  output WorkVars     vars_out
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = vars_in.h + bsig1(vars_in.e) + ch(vars_in.e, vars_in.f, vars_in.g) + k_in + w_in;
    t2 = bsig0(vars_in.a) + maj(vars_in.a, vars_in.b, vars_in.c);
    vars_out.a = t1 + t2;
    vars_out.b = vars_in.a;
    vars_out.c = vars_in.b;
    vars_out.d = vars_in.c;
    vars_out.e = vars_in.d + t1;
    vars_out.f = vars_in.e;
    vars_out.g = vars_in.f;
    vars_out.h = vars_in.g;
  end

endmodule

// File: rtl/sha256_iter_core.sv
// sha256_iter_core: iterative SHA-256/SHA-224 compression engine.
// Takes pre-padded 512-bit blocks, chains multi-block messages in its own H
// registers and emits the digest after the block flagged last. RPC rounds are
// applied per clock by a chain of sha256_round_comb instances; the message
// schedule is produced on the fly in a 16-word sliding window.
//   clk, rst              clock, synchronous active-high reset
//   blk_vld/blk_rdy       block handshake; blk_rdy only high in IDLE
//   blk_data              16 x 32-bit words, [0] is the first big-endian word
//   blk_first/blk_last    message boundaries
//   mode                  0 = SHA-256, 1 = SHA-224 (only with SHA224_EN=1)
//   digest_vld/digest_rdy digest handshake
//   digest                {H0..H7}, or {H0..H6,32'h0} for SHA-224
//   busy                  high whenever the engine is not IDLE
module sha256_iter_core
  import sha256_pkg::*;
#(
  parameter int RPC       = 1,
  parameter bit SHA224_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_vld,
  output logic              blk_rdy,
  input  logic [15:0][31:0] blk_data,
  input  logic              blk_first,
  input  logic              blk_last,
  input  logic              mode,
  output logic              digest_vld,
  input  logic              digest_rdy,
  output logic [255:0]      digest,
  output logic              busy
);

  generate
    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
      $error("sha256_iter_core: RPC must be 1, 2, 4 or 8");
    end
  endgenerate

  core_state_e      state_reg;
  logic [6:0]       t_reg;
  logic [15:0][31:0] w_reg;
  logic [0:7][31:0] h_reg;
  WorkVars          vars_reg;
  logic             mode_reg;
  logic             last_reg;
  logic             chain_active_reg;
  logic             blk_rdy_reg;
  logic             busy_reg;
  logic             digest_vld_reg;
  logic [255:0]     digest_reg;

  logic             mode_eff;
  logic [0:7][31:0] iv_sel;
  logic [0:7][31:0] vars_arr;
  logic [0:7][31:0] h_next;
  logic [255:0]     digest_next;
  logic [31:0]      ext [0:15+RPC];
  logic [15:0][31:0] w_next;
  logic [31:0]      k_word [0:RPC-1];
  WorkVars          round_vars [0:RPC];

  // With SHA-224 support compiled out the mode pin has no effect at all.
  assign mode_eff = SHA224_EN ? mode : 1'b0;
  assign iv_sel   = mode_eff ? IV224 : IV256;
  assign vars_arr = vars_reg;

  // Extended schedule view: ext[0..15] is the live window (ext[0] = W_t),
  // ext[16..15+RPC] are the next RPC words. Words beyond the first two new
  // ones depend on new words computed in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_win
      assign ext[gi]    = w_reg[gi];
      assign w_next[gi] = ext[gi+RPC];
    end
    for (gi = 0; gi < RPC; gi++) begin : g_sched
      assign ext[16+gi] = ssig1(ext[14+gi]) + ext[9+gi] + ssig0(ext[1+gi]) + ext[gi];
    end
  endgenerate

  // Round chain: RPC rounds t..t+RPC-1 per clock.
  assign round_vars[0] = vars_reg;
  generate
    for (gi = 0; gi < RPC; gi++) begin : g_round
      assign k_word[gi] = K[t_reg[5:0] + 6'(gi)];
      sha256_round_comb u_round (
        .vars_in  (round_vars[gi]),
        .k_in     (k_word[gi]),
        .w_in     (w_reg[gi]),
        .vars_out (round_vars[gi+1])
      );
    end
    for (gi = 0; gi < 8; gi++) begin : g_hsum
      assign h_next[gi] = h_reg[gi] + vars_arr[gi];
    end
  endgenerate

  assign digest_next = mode_reg ? {h_reg[0:6], 32'h0} : h_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      t_reg            <= 7'd0;
      w_reg            <= '0;
      h_reg            <= '0;
      vars_reg         <= '0;
      mode_reg         <= 1'b0;
      last_reg         <= 1'b0;
      chain_active_reg <= 1'b0;
      blk_rdy_reg      <= 1'b1;
      busy_reg         <= 1'b0;
      digest_vld_reg   <= 1'b0;
      digest_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (blk_vld && blk_rdy_reg) begin
            w_reg <= blk_data;
            t_reg <= 7'd0;
            // A new message (or a block arriving with no open chain) starts
            // from the IV and discards whatever chain was in progress.
            if (blk_first || !chain_active_reg) begin
              h_reg    <= iv_sel;
              vars_reg <= WorkVars'(iv_sel);
              mode_reg <= mode_eff;
            end else begin
              vars_reg <= WorkVars'(h_reg);
            end
            last_reg         <= blk_last;
            chain_active_reg <= 1'b1;
            blk_rdy_reg      <= 1'b0;
            busy_reg         <= 1'b1;
            state_reg        <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          vars_reg <= round_vars[RPC];
          w_reg    <= w_next;
          t_reg    <= t_reg + 7'(RPC);
          if (t_reg + 7'(RPC) == 7'd64) begin
            state_reg <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          h_reg <= h_next;
          if (last_reg) begin
            state_reg <= ST_OUT;
          end else begin
            blk_rdy_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        ST_OUT: begin
          // First OUT cycle captures the freshly committed H into the digest
          // register; it then holds until the sink takes it.
          if (!digest_vld_reg) begin
            digest_reg     <= digest_next;
            digest_vld_reg <= 1'b1;
          end else if (digest_rdy) begin
            digest_vld_reg   <= 1'b0;
            chain_active_reg <= 1'b0;
            blk_rdy_reg      <= 1'b1;
            busy_reg         <= 1'b0;
            state_reg        <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign blk_rdy    = blk_rdy_reg;
  assign busy       = busy_reg;
  assign digest_vld = digest_vld_reg;
  assign digest     = digest_reg;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Testbench for sha256_iter_core: four instances (RPC = 1,2,4,8; only the
// RPC=1 instance has SHA-224 enabled). Directed blocks are driven one
// instance at a time; expected digests and latencies go into a scoreboard
// queue and a negedge monitor checks them as digests appear.
module tb_sha256_iter_core;

  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] D_2BK = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0][31:0] blk_data = '0;
  logic              blk_first = 1'b0;
  logic              blk_last = 1'b0;
  logic              mode = 1'b0;
  logic              blk_vld [4];
  logic              blk_rdy [4];
  logic              dv [4];
  logic              drdy [4];
  logic [255:0]      dig [4];
  logic              busy [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int           inst;
    logic [255:0] dig;
    int           acc;
    int           lat;
  } exp_t;
  exp_t exp_q[$];
  bit   dv_prev [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      sha256_iter_core #(.RPC(1 << gi), .SHA224_EN(gi == 0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .blk_vld    (blk_vld[gi]),
        .blk_rdy    (blk_rdy[gi]),
        .blk_data   (blk_data),
        .blk_first  (blk_first),
        .blk_last   (blk_last),
        .mode       (mode),
        .digest_vld (dv[gi]),
        .digest_rdy (drdy[gi]),
        .digest     (dig[gi]),
        .busy       (busy[gi])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Drive one block into instance k; returns the cycle of the accepting edge.
  task automatic send(input int k, input logic [15:0][31:0] data, input logic first,
                      input logic last, input logic md, input bit expect_dig,
                      input logic [255:0] exp_dig, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    blk_data  = data;
    blk_first = first;
    blk_last  = last;
    mode      = md;
    blk_vld[k] = 1'b1;
    n = 0;
    while (!blk_rdy[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!blk_rdy[k]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout inst=%0d got=blk_rdy_low want=blk_rdy_high", k);
    end
    acc = cyc + 1;
    if (expect_dig) begin
      e.inst = k;
      e.dig  = exp_dig;
      e.acc  = acc;
      e.lat  = (64 >> k) + 2;
      exp_q.push_back(e);
    end
    $display("tx inst=%0d first=%0b last=%0b mode=%0b accept_cycle=%0d", k, first, last, md, acc);
    @(negedge clk);
    blk_vld[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d_pending want=0_pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor: latency on the rising digest_vld, value on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (dv[k] && !dv_prev[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_digest inst=%0d got=%h want=none", k, dig[k]);
          end else begin
            chk("digest_inst", 256'(k), 256'(exp_q[0].inst));
            chk("latency", 256'(cyc - exp_q[0].acc), 256'(exp_q[0].lat));
          end
        end
        if (dv[k] && drdy[k] && exp_q.size() != 0) begin
          chk("digest", dig[k], exp_q[0].dig);
          $display("rx inst=%0d digest=%h", k, dig[k]);
          void'(exp_q.pop_front());
        end
        dv_prev[k] = dv[k];
      end
    end
  end

  logic [15:0][31:0] blk_abc;
  logic [15:0][31:0] blk_m1;
  logic [15:0][31:0] blk_m2;
  logic [31:0]       m1w [16];

  initial begin
    int a1;
    int a2;
    int n;
    for (int k = 0; k < 4; k++) begin
      blk_vld[k] = 1'b0;
      drdy[k]    = 1'b1;
      dv_prev[k] = 1'b0;
    end
    m1w = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_abc = '0;
    blk_abc[0] = 32'h61626380;
    blk_abc[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) blk_m1[i] = m1w[i];
    blk_m2 = '0;
    blk_m2[15] = 32'h000001c0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_blk_rdy", 256'(blk_rdy[k]), 256'd1);
      chk("reset_digest_vld", 256'(dv[k]), 256'd0);
      chk("reset_busy", 256'(busy[k]), 256'd0);
      chk("reset_digest", dig[k], 256'd0);
    end

    // T1: "abc", SHA-256
    send(0, blk_abc, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC, a1);
    drain();
    // T2: "abc", SHA-224
    send(0, blk_abc, 1'b1, 1'b1, 1'b1, 1'b1, D_224, a1);
    drain();
    // T3: two-block message, chained internally
    send(0, blk_m1, 1'b1, 1'b0, 1'b0, 1'b0, '0, a1);
    chk("busy_in_round", 256'(busy[0]), 256'd1);
    send(0, blk_m2, 1'b0, 1'b1, 1'b0, 1'b1, D_2BK, a2);
    chk("block_spacing_rpc1", 256'(a2 - a1), 256'd66);
    drain();
    // blk_first on an open chain restarts from the IV
    send(0, blk_m1, 1'b1, 1'b0, 1'b0, 1'b0, '0, a1);
    send(0, blk_abc, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC, a1);
    drain();

    // T4: sink stalls for 10 cycles
    drdy[0] = 1'b0;
    send(0, blk_abc, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC, a1);
    n = 0;
    while (!dv[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("stall_vld_seen", 256'(dv[0]), 256'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_vld", 256'(dv[0]), 256'd1);
      chk("stall_digest", dig[0], D_ABC);
      chk("stall_blk_rdy", 256'(blk_rdy[0]), 256'd0);
    end
    @(posedge clk);
    #1 drdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_vld", 256'(dv[0]), 256'd0);
    chk("post_hs_blk_rdy", 256'(blk_rdy[0]), 256'd1);
    chk("post_hs_busy", 256'(busy[0]), 256'd0);
    drain();

    // T5: reset in the middle of the rounds of an open (non-last) block
    send(0, blk_m1, 1'b1, 1'b0, 1'b0, 1'b0, '0, a1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_vld", 256'(dv[0]), 256'd0);
    chk("midrst_busy", 256'(busy[0]), 256'd0);
    chk("midrst_blk_rdy", 256'(blk_rdy[0]), 256'd1);
    // first=0: must still start from IV since the chain was dropped
    send(0, blk_abc, 1'b0, 1'b1, 1'b0, 1'b1, D_ABC, a1);
    drain();

    // T6: RPC = 2,4,8 (SHA-224 disabled, so mode=1 is ignored)
    for (int k = 1; k < 4; k++) begin
      send(k, blk_abc, 1'b1, 1'b1, 1'b1, 1'b1, D_ABC, a1);
      drain();
      send(k, blk_m1, 1'b1, 1'b0, 1'b0, 1'b0, '0, a1);
      send(k, blk_m2, 1'b0, 1'b1, 1'b0, 1'b1, D_2BK, a2);
      chk("block_spacing", 256'(a2 - a1), 256'((64 >> k) + 2));
      drain();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
